// File: rtl/target_controller_pkg.sv
// Shared definitions for the target controller: FSM state encoding and LFSR constants.
// game_start and game_score use the same encoding style.
package target_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/target_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a nonzero seed keeps it out of the all-zero lock-up state.
module lfsr16
    import target_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= seed;
        else     q <= lfsr_next(q);
    end

endmodule

// File: rtl/target_controller.sv
// Round target owner: spawns at a pseudo-random LED, steps every MOVE_TICKS cycles,
// and resolves each shot into a one-cycle hit or miss pulse.
module target_controller
    import target_controller_pkg::*;
#(
    parameter int          NUM_POS    = 16,
    parameter int          POS_W      = 4,
    parameter int          MOVE_TICKS = 50000000,
    parameter int          HOLD_TICKS = 25000000,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               jump_start,
    input  logic               shoot,
    input  logic [POS_W-1:0]   aim,
    output logic [POS_W-1:0]   target_pos,
    output logic [NUM_POS-1:0] target_led,
    output logic               hit,
    output logic               miss,
    output logic               busy
);

    localparam int MOVE_W = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    state_t               state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [NUM_POS-1:0]   led_q, led_d;
    logic                 hit_q, hit_d, miss_q, miss_d, busy_q, busy_d;
    logic                 dir_q, dir_d;
    logic [MOVE_W-1:0]    move_q, move_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [15:0]          lfsr_q;
    logic [POS_W-1:0]     cand, spawn_pos, step_pos;
    logic                 lfsr_unused;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    // Only the low position bits and the direction bit feed the spawn
    assign lfsr_unused = ^lfsr_q[14:POS_W];

    assign cand      = lfsr_q[POS_W-1:0];
    assign spawn_pos = (cand == pos_q) ? cand + POS_W'(1) : cand;
    assign step_pos  = dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        move_d  = move_q;
        hold_d  = hold_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;

        case (state_q)
            IDLE: begin
                move_d = '0;
                hold_d = '0;
                if (start && jump_start) begin
                    state_d = ACTIVE;
                    pos_d   = spawn_pos;
                    dir_d   = lfsr_q[15];
                end
            end
            ACTIVE: begin
                if (!start) begin
                    state_d = IDLE;
                    move_d  = '0;
                    hold_d  = '0;
                end else if (shoot && (aim == pos_q)) begin
                    // Hit compares against the pre-step position and cancels a coincident step
                    hit_d   = 1'b1;
                    state_d = HOLD;
                    hold_d  = '0;
                    move_d  = '0;
                end else begin
                    miss_d = shoot;
                    if (move_q == MOVE_LAST) begin
                        pos_d  = step_pos;
                        move_d = '0;
                    end else begin
                        move_d = move_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!start) begin
                    state_d = IDLE;
                    move_d  = '0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ACTIVE;
                    pos_d   = spawn_pos;
                    dir_d   = lfsr_q[15];
                    move_d  = '0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        led_d  = (state_d == ACTIVE) ? (NUM_POS'(1) << pos_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            led_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            busy_q  <= 1'b0;
            dir_q   <= 1'b0;
            move_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
            dir_q   <= dir_d;
            move_q  <= move_d;
            hold_q  <= hold_d;
        end
    end

    assign target_pos = pos_q;
    assign target_led = led_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_target_controller.sv
// Randomized scoreboard bench for target_controller; the reference model derives the target
// position arithmetically from the spawn time instead of tracking per-cycle counters.
module tb_target_controller;

    localparam int          NP   = 16;
    localparam int          PW   = 4;
    localparam int          MT   = 4;
    localparam int          HT   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst, start, jump_start, shoot;
    logic [PW-1:0] aim;
    logic [PW-1:0] target_pos;
    logic [NP-1:0] target_led;
    logic          hit, miss, busy;

    always #5 clk = ~clk;

    target_controller #(
        .NUM_POS    (NP),
        .POS_W      (PW),
        .MOVE_TICKS (MT),
        .HOLD_TICKS (HT),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .jump_start (jump_start),
        .shoot      (shoot),
        .aim        (aim),
        .target_pos (target_pos),
        .target_led (target_led),
        .hit        (hit),
        .miss       (miss),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        bit is_hit;
    } pulse_t;
    pulse_t sb[$];

    // Reference model state: mode 0 idle, 1 playing, 2 blanked after a hit
    int          cyc = 0;
    int          mode = 0;
    int          frozen = 0;
    int          sp_pos = 0, sp_dir = 0, sp_cyc = 0, hold_el = 0;
    int          cur;
    bit [15:0]   m_lfsr = SEED;
    bit [15:0]   lpre;
    bit          armed = 0;
    int          exp_pos = 0;
    bit          exp_busy = 0;
    bit [15:0]   exp_led = '0;
    pulse_t      pt;

    function automatic int pos_after(int c);
        int steps = (c - sp_cyc) / MT;
        int p = (sp_dir != 0) ? sp_pos - steps : sp_pos + steps;
        return ((p % NP) + NP) % NP;
    endfunction

    function automatic void do_spawn(bit [15:0] l);
        int c = int'(l[3:0]);
        if (c == frozen) c = (c + 1) % NP;
        sp_pos = c;
        sp_dir = int'(l[15]);
        sp_cyc = cyc;
        mode   = 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            mode   = 0;
            frozen = 0;
            m_lfsr = SEED;
            armed  = 1;
        end else begin
            lpre = m_lfsr;
            case (mode)
                0: if (start && jump_start) do_spawn(lpre);
                1: begin
                    cur = pos_after(cyc - 1);
                    if (!start) begin
                        mode   = 0;
                        frozen = cur;
                    end else if (shoot) begin
                        pt.cyc = cyc;
                        pt.is_hit = (int'(aim) == cur);
                        sb.push_back(pt);
                        if (pt.is_hit) begin
                            mode    = 2;
                            frozen  = cur;
                            hold_el = 0;
                        end
                    end
                end
                default: begin
                    if (!start)              mode = 0;
                    else if (hold_el == HT-1) do_spawn(lpre);
                    else                     hold_el++;
                end
            endcase
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        exp_pos  = (mode == 1) ? pos_after(cyc) : frozen;
        exp_busy = (mode != 0);
        exp_led  = (mode == 1) ? (16'(1) << exp_pos) : 16'h0;
    end

    // Monitor: per-cycle output checks and scoreboard pops for hit/miss pulses
    always @(negedge clk) begin
        if (armed) begin
            chk("target_pos", 32'(target_pos), 32'(exp_pos));
            chk("target_led", 32'(target_led), 32'(exp_led));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("lfsr_nonzero", 32'(dut.lfsr_q != 16'h0), 32'd1);
            chk("lfsr_seq", 32'(dut.lfsr_q), 32'(m_lfsr));
            chk("hit_miss_excl", 32'(hit && miss), 32'd0);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("pulse_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk("pulse_hit", 32'(hit), 32'(sb[0].is_hit));
                chk("pulse_miss", 32'(miss), 32'(!sb[0].is_hit));
                void'(sb.pop_front());
            end else begin
                chk("no_pulse", 32'(hit || miss), 32'd0);
            end
        end
    end

    task automatic fire(input logic [PW-1:0] a);
        aim   = a;
        shoot = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
    endtask

    task automatic jump();
        jump_start = 1'b1;
        @(negedge clk);
        jump_start = 1'b0;
    endtask

    task automatic wait_active(int lim);
        int n = 0;
        while (target_led == '0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_active", 32'(target_led != '0), 32'd1);
    endtask

    int old_pos;
    int n;

    initial begin
        rst = 1'b1; start = 1'b0; jump_start = 1'b0; shoot = 1'b0; aim = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle with start low: jump and shoot noise must be ignored
        repeat (20) begin
            @(negedge clk);
            jump_start = 1'($urandom % 2);
            shoot      = 1'($urandom % 2);
            aim        = PW'($urandom);
        end
        jump_start = 1'b0; shoot = 1'b0;
        @(negedge clk);

        // Spawn and a full lap of movement so the wrap is exercised
        start = 1'b1;
        jump();
        chk("busy_after_jump", 32'(busy), 32'd1);
        repeat (70) @(negedge clk);

        // Hit, ignored shot during hold, respawn elsewhere
        old_pos = int'(target_pos);
        fire(target_pos);
        chk("hit_pulse", 32'(hit), 32'd1);
        fire(PW'(old_pos));
        wait_active(10);
        chk("respawn_differs", 32'(int'(target_pos) != old_pos), 32'd1);

        // Miss keeps the round active
        repeat (5) @(negedge clk);
        fire(target_pos ^ PW'(1));
        chk("miss_pulse", 32'(miss), 32'd1);
        repeat (10) @(negedge clk);

        // Hit landing on the step cycle
        n = 0;
        while (!(mode == 1 && ((cyc + 1 - sp_cyc) % MT) == 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_step_cycle", 32'(n < 20), 32'd1);
        old_pos = int'(target_pos);
        fire(target_pos);
        chk("step_hit", 32'(hit), 32'd1);
        chk("step_suppressed", 32'(target_pos), 32'(old_pos));

        // start drops mid-ACTIVE with a simultaneous shot
        wait_active(10);
        repeat (2) @(negedge clk);
        start = 1'b0;
        fire(target_pos);
        chk("drop_active_busy", 32'(busy), 32'd0);
        start = 1'b1;
        jump();
        wait_active(10);

        // start drops mid-HOLD
        fire(target_pos);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("drop_hold_busy", 32'(busy), 32'd0);
        chk("drop_hold_led", 32'(target_led), 32'd0);

        // rst mid-ACTIVE
        start = 1'b1;
        jump();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pos", 32'(target_pos), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Randomized play
        repeat (800) begin
            start      = (($urandom % 64) != 0);
            jump_start = (($urandom % 8) == 0);
            shoot      = (($urandom % 5) == 0);
            aim        = ($urandom % 2 != 0) ? PW'(exp_pos) : PW'($urandom);
            rst        = (($urandom % 300) == 0);
            @(negedge clk);
        end
        rst = 1'b0; shoot = 1'b0; jump_start = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
